// File: rtl/mux_sel_arbiter.sv
// Two-requester arbiter driving a tristate 2:1 mux: round-robin, hold-time
// preemption and break-before-make dead time between owners.
module mux_sel_arbiter #(
   parameter int HOLD_MAX = 8,
   parameter int DEAD_CYC = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req0,
   input  logic req1,
   output logic gnt0,
   output logic gnt1,
   output logic s,
   output logic busy,
   output logic last
);

   localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);
   localparam logic [1:0] DEAD_LIM = 2'(DEAD_CYC);

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, TURN} state_t;

   state_t     state_q, state_d;
   logic [7:0] hold_q, hold_d;
   logic [1:0] dead_q, dead_d;
   logic       last_q, last_d;
   logic       s_q, s_d;

   logic pick_vld, pick_idx, do_grant;
   logic own, mine, other;

   // Round-robin: the side that was not granted last wins a tie.
   always_comb begin
      pick_vld = req0 | req1;
      pick_idx = last_q;
      if (last_q ? req0 : req1) pick_idx = ~last_q;
   end

   always_comb begin
      state_d  = state_q;
      hold_d   = hold_q;
      dead_d   = dead_q;
      last_d   = last_q;
      s_d      = s_q;
      do_grant = 1'b0;
      own      = (state_q == GRANT1);
      mine     = own ? req1 : req0;
      other    = own ? req0 : req1;
      case (state_q)
         IDLE: begin
            hold_d   = 8'd0;
            dead_d   = 2'd0;
            do_grant = pick_vld;
         end
         GRANT0, GRANT1: begin
            if (!mine || (hold_q == HOLD_LIM && other)) begin
               state_d = TURN;
               dead_d  = 2'd1;
               hold_d  = 8'd0;
            end else if (hold_q != HOLD_LIM) begin
               hold_d = hold_q + 8'd1;
            end
         end
         TURN: begin
            if (dead_q == DEAD_LIM) begin
               do_grant = pick_vld;
               if (!pick_vld) begin
                  state_d = IDLE;
                  dead_d  = 2'd0;
               end
            end else begin
               dead_d = dead_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (do_grant) begin
         state_d = pick_idx ? GRANT1 : GRANT0;
         hold_d  = 8'd1;
         dead_d  = 2'd0;
         last_d  = pick_idx;
         s_d     = pick_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         hold_q  <= 8'd0;
         dead_q  <= 2'd0;
         last_q  <= 1'b1;
         s_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         dead_q  <= dead_d;
         last_q  <= last_d;
         s_q     <= s_d;
      end
   end

   assign gnt0 = (state_q == GRANT0);
   assign gnt1 = (state_q == GRANT1);
   assign busy = (state_q != IDLE);
   assign s    = s_q;
   assign last = last_q;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Bench for mux_sel_arbiter: two configurations driven in lockstep against an
// owner/tenure/dead-time model, plus directed sequences with literal values.
module tb_mux_sel_arbiter;

   localparam int HM[2] = '{4, 8};
   localparam int DC[2] = '{2, 1};

   logic clk, rst_n, req0, req1;
   logic [1:0] g0, g1, so, bz, la;

   mux_sel_arbiter #(.HOLD_MAX(4), .DEAD_CYC(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .gnt0(g0[0]), .gnt1(g1[0]), .s(so[0]), .busy(bz[0]), .last(la[0]));
   mux_sel_arbiter #(.HOLD_MAX(8), .DEAD_CYC(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
      .gnt0(g0[1]), .gnt1(g1[1]), .s(so[1]), .busy(bz[1]), .last(la[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: own = -1 idle, 0/1 owner, 2 dead time; ten = cycles owned; dl = dead cycles left.
   int own[2], ten[2], dl[2], lst[2], sel[2];
   int prev_own[2], low_run[2];
   int n_run, n_fail;

   function automatic int pick(int l, logic r0, logic r1);
      if ((l == 1) ? r0 : r1) return 1 - l;
      if ((l == 1) ? r1 : r0) return l;
      return -1;
   endfunction

   task automatic start(int i, int p);
      own[i] = p; ten[i] = 1; lst[i] = p; sel[i] = p;
   endtask

   task automatic model_edge();
      int p;
      logic mine, oth;
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            own[i] = -1; ten[i] = 0; dl[i] = 0; lst[i] = 1; sel[i] = 0;
            prev_own[i] = -1; low_run[i] = 0;
         end else if (own[i] == -1) begin
            p = pick(lst[i], req0, req1);
            if (p >= 0) start(i, p);
         end else if (own[i] == 2) begin
            dl[i]--;
            if (dl[i] == 0) begin
               p = pick(lst[i], req0, req1);
               if (p >= 0) start(i, p);
               else own[i] = -1;
            end
         end else begin
            mine = own[i] ? req1 : req0;
            oth  = own[i] ? req0 : req1;
            if (!mine || (ten[i] == HM[i] && oth)) begin
               own[i] = 2; dl[i] = DC[i];
            end else if (ten[i] < HM[i]) begin
               ten[i]++;
            end
         end
      end
   endtask

   task automatic chk(string nm, int got, int exp);
      n_run++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic compare_all();
      int cur;
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("gnt0[%0d]", i), g0[i], own[i] == 0);
         chk($sformatf("gnt1[%0d]", i), g1[i], own[i] == 1);
         chk($sformatf("s[%0d]", i), so[i], sel[i]);
         chk($sformatf("busy[%0d]", i), bz[i], own[i] != -1);
         chk($sformatf("last[%0d]", i), la[i], lst[i]);
         chk($sformatf("overlap[%0d]", i), g0[i] & g1[i], 0);
         if (g0[i] | g1[i]) begin
            cur = g1[i] ? 1 : 0;
            if (prev_own[i] >= 0 && cur != prev_own[i])
               chk($sformatf("deadtime[%0d]", i), low_run[i] >= DC[i], 1);
            prev_own[i] = cur;
            low_run[i]  = 0;
         end else begin
            low_run[i]++;
         end
      end
   endtask

   task automatic step(logic a0, logic a1, logic an);
      req0 = a0; req1 = a1; rst_n = an;
      @(posedge clk);
      model_edge();
      #2;
      compare_all();
   endtask

   initial begin
      n_run = 0; n_fail = 0;
      for (int i = 0; i < 2; i++) begin
         own[i] = -1; ten[i] = 0; dl[i] = 0; lst[i] = 1; sel[i] = 0;
         prev_own[i] = -1; low_run[i] = 0;
      end

      // reset with both requesting, then fairness on A (hold 4, dead 2)
      repeat (3) step(1, 1, 0);
      chk("rst gnt0", g0[0], 0); chk("rst gnt1", g1[0], 0);
      chk("rst s", so[0], 0); chk("rst busy", bz[0], 0); chk("rst last", la[0], 1);
      step(1, 1, 1);
      chk("first gnt0", g0[0], 1); chk("first s", so[0], 0);
      repeat (3) step(1, 1, 1);
      chk("hold4 gnt0", g0[0], 1);
      step(1, 1, 1);
      chk("preempt gnt0", g0[0], 0); chk("preempt busy", bz[0], 1); chk("turn s", so[0], 0);
      step(1, 1, 1);
      chk("dead2 gnt1", g1[0], 0);
      step(1, 1, 1);
      chk("rr gnt1", g1[0], 1); chk("rr s", so[0], 1); chk("rr last", la[0], 1);
      repeat (12) step(1, 1, 1);

      // single requester on B (dead 1)
      step(0, 0, 0);
      repeat (5) step(0, 1, 1);
      chk("single gnt1", g1[1], 1); chk("single s", so[1], 1);
      step(0, 0, 1);
      chk("rel gnt1", g1[1], 0); chk("rel busy", bz[1], 1); chk("rel s", so[1], 1);
      step(0, 0, 1);
      chk("idle busy", bz[1], 0); chk("idle last", la[1], 1);

      // no competitor: unlimited grant
      step(0, 0, 0);
      for (int k = 0; k < 20; k++) begin
         step(1, 0, 1);
         chk("nocomp gnt0", g0[0], 1);
      end

      // mid-grant reset
      step(0, 0, 0);
      repeat (2) step(0, 1, 1);
      chk("pre-rst gnt1", g1[0], 1);
      step(1, 1, 0);
      chk("midrst gnt1", g1[0], 0); chk("midrst s", so[0], 0); chk("midrst busy", bz[0], 0);
      step(1, 1, 1);
      chk("post-rst gnt0", g0[0], 1);

      // drop coincides with preemption on A
      step(0, 0, 0);
      step(1, 0, 1);
      repeat (3) step(1, 1, 1);
      step(0, 1, 1);
      chk("drop gnt0", g0[0], 0); chk("drop busy", bz[0], 1);
      step(0, 1, 1);
      chk("drop dead gnt1", g1[0], 0);
      step(0, 1, 1);
      chk("drop gnt1", g1[0], 1); chk("drop s", so[0], 1);

      // randomized traffic with occasional reset
      for (int k = 0; k < 3000; k++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 99) != 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
